// File: rtl/updown_sequencer.sv
// Programmable up/down/ping-pong/one-shot counter sequencer.
// A run is configured at start, counts between inclusive limits and stops
// after a set number of passes (or on stop). Every output is registered.
module updown_sequencer #(
    parameter int unsigned BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      mode,
    input  logic [BITS-1:0] lo_lim,
    input  logic [BITS-1:0] hi_lim,
    input  logic [7:0]      passes,
    output logic [BITS-1:0] count,
    output logic            dir,
    output logic            busy,
    output logic            done,
    output logic            wrap,
    output logic            err
);

    localparam int unsigned PW = 8;
    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_PP   = 2'd2;
    localparam logic [1:0] MODE_ONE  = 2'd3;

    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    state_t          state, state_nxt;
    logic [BITS-1:0] count_nxt;
    logic            dir_nxt, busy_nxt, done_nxt, wrap_nxt, err_nxt;
    logic [PW-1:0]   pass_cnt, pass_nxt;
    logic [1:0]      cfg_mode, mode_nxt;
    logic [BITS-1:0] cfg_lo, lo_nxt;
    logic [BITS-1:0] cfg_hi, hi_nxt;
    logic [PW-1:0]   cfg_passes, passes_nxt;
    logic [PW-1:0]   pass_inc;
    logic            last_pass;

    // Saturating pass increment and terminal-pass detection (0 = endless).
    assign pass_inc  = (pass_cnt == {PW{1'b1}}) ? pass_cnt : pass_cnt + PW'(1);
    assign last_pass = (cfg_passes != '0) && (pass_inc == cfg_passes);

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
            err        <= 1'b0;
            pass_cnt   <= '0;
            cfg_mode   <= '0;
            cfg_lo     <= '0;
            cfg_hi     <= '0;
            cfg_passes <= '0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            dir        <= dir_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            wrap       <= wrap_nxt;
            err        <= err_nxt;
            pass_cnt   <= pass_nxt;
            cfg_mode   <= mode_nxt;
            cfg_lo     <= lo_nxt;
            cfg_hi     <= hi_nxt;
            cfg_passes <= passes_nxt;
        end
    end

    // Next-state, count and pulse logic; stop outranks limit/pass events.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        dir_nxt    = dir;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        wrap_nxt   = 1'b0;
        err_nxt    = 1'b0;
        pass_nxt   = pass_cnt;
        mode_nxt   = cfg_mode;
        lo_nxt     = cfg_lo;
        hi_nxt     = cfg_hi;
        passes_nxt = cfg_passes;

        case (state)
            IDLE: begin
                if (start) begin
                    if (lo_lim > hi_lim) begin
                        err_nxt = 1'b1;
                    end else begin
                        mode_nxt   = mode;
                        lo_nxt     = lo_lim;
                        hi_nxt     = hi_lim;
                        passes_nxt = passes;
                        pass_nxt   = '0;
                        busy_nxt   = 1'b1;
                        if (mode == MODE_DOWN) begin
                            count_nxt = hi_lim;
                            dir_nxt   = 1'b1;
                            state_nxt = DOWN;
                        end else begin
                            count_nxt = lo_lim;
                            dir_nxt   = 1'b0;
                            state_nxt = UP;
                        end
                    end
                end
            end

            UP: begin
                if (stop) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else if (cfg_lo == cfg_hi) begin
                    // Single-point range: every cycle is a full pass.
                    wrap_nxt = 1'b1;
                    pass_nxt = pass_inc;
                    if (cfg_mode == MODE_ONE || last_pass) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end else if (count < cfg_hi) begin
                    count_nxt = count + BITS'(1);
                end else if (cfg_mode == MODE_PP) begin
                    state_nxt = DOWN;
                    dir_nxt   = 1'b1;
                    count_nxt = cfg_hi - BITS'(1);
                end else if (cfg_mode == MODE_ONE) begin
                    wrap_nxt  = 1'b1;
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    wrap_nxt = 1'b1;
                    pass_nxt = pass_inc;
                    if (last_pass) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        count_nxt = cfg_lo;
                    end
                end
            end

            DOWN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else if (cfg_lo == cfg_hi) begin
                    wrap_nxt = 1'b1;
                    pass_nxt = pass_inc;
                    if (last_pass) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end else if (count > cfg_lo) begin
                    count_nxt = count - BITS'(1);
                end else begin
                    wrap_nxt = 1'b1;
                    pass_nxt = pass_inc;
                    if (last_pass) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else if (cfg_mode == MODE_PP) begin
                        state_nxt = UP;
                        dir_nxt   = 1'b0;
                        count_nxt = cfg_lo + BITS'(1);
                    end else begin
                        count_nxt = cfg_hi;
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_updown_sequencer.sv
// Directed, table-driven bench for updown_sequencer (BITS=4).
module tb_updown_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] lo_lim;
    logic [3:0] hi_lim;
    logic [7:0] passes;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic [1:0] mode;
        logic [3:0] lo;
        logic [3:0] hi;
        logic [7:0] passes;
        logic [8:0] exp;   // {count, dir, busy, done, wrap, err}
    } vec_t;

    vec_t vecs[$];

    updown_sequencer #(.BITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .lo_lim (lo_lim),
        .hi_lim (hi_lim),
        .passes (passes),
        .count  (count),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .wrap   (wrap),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {count, dir, busy, done, wrap, err};
    endfunction

    function automatic logic [8:0] pack(input int c, input int d, input int b,
                                        input int dn, input int w, input int e);
        return {4'(c), 1'(d), 1'(b), 1'(dn), 1'(w), 1'(e)};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cnt=%0d dir=%b busy=%b done=%b wrap=%b err=%b, expected cnt=%0d dir=%b busy=%b done=%b wrap=%b err=%b",
                     name, act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input int r, input int s, input int p, input int m,
                       input int lo, input int hi, input int ps,
                       input int c, input int d, input int b,
                       input int dn, input int w, input int e);
        vec_t v;
        v.rst    = 1'(r);
        v.start  = 1'(s);
        v.stop   = 1'(p);
        v.mode   = 2'(m);
        v.lo     = 4'(lo);
        v.hi     = 4'(hi);
        v.passes = 8'(ps);
        v.exp    = pack(c, d, b, dn, w, e);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic p, input int m,
                         input int lo, input int hi, input int ps);
        start  = s;
        stop   = p;
        mode   = 2'(m);
        lo_lim = 4'(lo);
        hi_lim = 4'(hi);
        passes = 8'(ps);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0, 0);

        //   rst st sp md lo hi ps   cnt dir busy done wrap err
        // reset held, start ignored
        add(0, 1, 0, 0, 2, 5, 2,    0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 2, 5, 2,    0, 0, 0, 0, 0, 0);
        // mode0 lo=2 hi=5 passes=2; inputs garbled after capture
        add(1, 1, 0, 0, 2, 5, 2,    2, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 9, 1, 0,    3, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 9, 1, 0,    4, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 9, 1, 0,    5, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 9, 1, 0,    2, 0, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0, 15, 0,   3, 0, 1, 0, 0, 0);  // start while busy
        add(1, 0, 0, 0, 9, 1, 0,    4, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 9, 1, 0,    5, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 9, 1, 0,    5, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 9, 1, 0,    5, 0, 0, 0, 0, 0);
        // mode2 ping-pong lo=1 hi=3 passes=1
        add(1, 1, 0, 2, 1, 3, 1,    1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    2, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    3, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    2, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    1, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    1, 1, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,    1, 1, 0, 0, 0, 0);
        // rejected start lo=6 > hi=4
        add(1, 1, 0, 0, 6, 4, 0,    1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 6, 4, 0,    1, 1, 0, 0, 0, 0);
        // mode3 lo=hi=7, start together with stop counts as start
        add(1, 1, 1, 3, 7, 7, 0,    7, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    7, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,    7, 0, 0, 0, 0, 0);
        // mode0 lo=hi=4 passes=3: a pass every cycle
        add(1, 1, 0, 0, 4, 4, 3,    4, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    4, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,    4, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,    4, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0,    4, 0, 0, 0, 0, 0);
        // stop at hi on the final pass beats the done event
        add(1, 1, 0, 0, 0, 1, 1,    0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            drive(vecs[i].start, vecs[i].stop, int'(vecs[i].mode), int'(vecs[i].lo),
                  int'(vecs[i].hi), int'(vecs[i].passes));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // mode1 lo=0 hi=15 endless, stop after 20 cycles
        drive(1'b1, 1'b0, 1, 0, 15, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0, 0, 0, 0, 0);
            check($sformatf("down_run%0d", i), outs(),
                  pack((15 - i) & 15, 1, 1, 0, (i == 16) ? 1 : 0, 0));
        end
        stop = 1'b1;
        @(posedge clk);
        #1;
        check("down_stop", outs(), pack(12, 1, 0, 0, 0, 0));
        stop = 1'b0;
        @(posedge clk);
        #1;
        check("down_stop_hold", outs(), pack(12, 1, 0, 0, 0, 0));

        // asynchronous reset mid-run in mode0
        drive(1'b1, 1'b0, 0, 2, 5, 0);
        @(posedge clk);
        #1;
        check("rst_run_start", outs(), pack(2, 0, 1, 0, 0, 0));
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_run_step", outs(), pack(3, 0, 1, 0, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", outs(), pack(0, 0, 0, 0, 0, 0));
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_start_ignored%0d", i), outs(), pack(0, 0, 0, 0, 0, 0));
        end
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_idle", outs(), pack(0, 0, 0, 0, 0, 0));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("rst_new_start", outs(), pack(2, 0, 1, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
